gpio_mmio: RTL and testbench
============================

# gpio_mmio

Parametrised memory-mapped GPIO peripheral for the RISC SoC. It sits behind the memory controller's GPIO window and replaces the fixed-width switch/LED/hex GPIO. It is generalised in input width, output width and hex-digit count. Compared with the fixed GPIO it adds input synchronisers, atomic set/clear/toggle output writes, per-bit edge capture with write-1-to-clear status, and a level interrupt.

## Interface
- N_IN, 17, number of input pins (1–32)
- N_OUT, 27, number of output pins (1–32); maps to 18 red plus 9 green LEDs
- N_HEX, 1, number of 4-bit hex digit fields (1–8)
- OUT_RESET, 0, reset value of the output register (N_OUT bits)
- DEB_CYCLES, 16, debounce stability window in cycles (≥2); used only with the debounce macro
- CLK  in  1  system clock; all state updates on the rising edge
- RESET_N  in  1  reset, synchronous, active-low
- DIN  in  N_IN  asynchronous input pins
- address  in  11  byte address from the memory controller; decode uses address[5:2]
- MemGPIOWrite  in  1  write strobe, single cycle
- MemGPIO  in  32  write data
- read_data_GPIO  out  32  read data, combinational from address and register state
- DOUT  out  N_OUT  output register
- HEX  out  4*N_HEX  hex digit register
- IRQ  out  1  OR of EDGE_STATUS bits, registered

## Operation
Register map (byte offset: name, access):
- 0x00 IN_DATA, RO: conditioned input value (stable)
- 0x04 OUT_DATA, RW
- 0x08 OUT_SET, WO: OUT |= wdata
- 0x0C OUT_CLR, WO: OUT &= ~wdata
- 0x10 OUT_TGL, WO: OUT ^= wdata
- 0x14 RISE_EN, RW: per-input rising-edge capture enable
- 0x18 FALL_EN, RW: per-input falling-edge capture enable
- 0x1C EDGE_STATUS, RW1C: writing 1 clears the corresponding bit
- 0x20 HEX_DATA, RW

General rules:
- Bits beyond a register's width read 0 and are ignored on write.
- WO registers read 0.
- Unmapped offsets (0x24–0x3C) read 0; writes to them have no effect.

Input path:
- DIN passes through a 2-flop synchroniser (sync1, sync2).
- Without debounce, stable = sync2.
- A prev register holds the previous stable value.
- rise = stable & ~prev & RISE_EN; fall = ~stable & prev & FALL_EN.
- Next EDGE_STATUS = (EDGE_STATUS & ~w1c_mask) | rise | fall.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- IRQ <= |next EDGE_STATUS.

Reset (RESET_N low at a clock edge), regardless of any in-flight activity:
- OUT = OUT_RESET; HEX = 0; RISE_EN = FALL_EN = 0; EDGE_STATUS = 0; IRQ = 0.
- sync1, sync2, stable, prev and debounce counters = 0.
- read_data_GPIO then reflects the reset state.
- A write coincident with reset is discarded.

## Timing
- Write: takes effect at the clock edge where MemGPIOWrite = 1; DOUT and HEX show the new value immediately after that edge.
- Read: same-cycle combinational; no wait states.
- Input latency without debounce: DIN changes before edge k; IN_DATA shows the new value after edge k+1.
- Edge capture: EDGE_STATUS bit and IRQ set after edge k+2.
- RISE_EN/FALL_EN written at edge j apply to transitions evaluated from edge j+1 onward.
- Edges on disabled bits are lost, not held pending.
- Exactly one write per cycle; register accesses are never combined in a cycle.

## Configuration
- GPIO_DEBOUNCE_EN defined:
  - Each input bit has a counter of width $clog2(DEB_CYCLES).
  - While sync2 ≠ stable, the counter increments each cycle.
  - If sync2 reverts to equal stable before the window completes, the counter clears.
  - stable <= sync2 at the edge where the counter equals DEB_CYCLES−1, and the counter clears.
  - Input-to-IN_DATA latency is therefore 1 + DEB_CYCLES edges after edge k. Edge capture is one cycle after that.
  - Glitches shorter than DEB_CYCLES cycles are rejected.
- GPIO_DEBOUNCE_EN undefined: no counters; stable = sync2; DEB_CYCLES ignored.

## Test plan
- Reset with OUT_RESET = 0x5: DOUT = 0x5, HEX = 0, IRQ = 0; reads of 0x1C and 0x00 (DIN held at 0) return 0.
- Output atomics: write 0xF0 to 0x04, 0x0F to 0x08, 0x30 to 0x0C, 0x81 to 0x10. DOUT is 0xF0, 0xFF, 0xCF, 0x4E after successive edges; 0x08 reads 0.
- Edge capture (no debounce): RISE_EN = 0x1, FALL_EN = 0x2. Raise DIN[0] before edge k: EDGE_STATUS = 0x1 and IRQ = 1 after edge k+2. Drop DIN[1] from 1: bit 1 also sets. Write 0x1 to 0x1C: status = 0x2, IRQ stays 1. Write 0x2: status = 0, IRQ = 0 next edge.
- Set/clear collision: time a W1C of bit 0 to coincide with a new rising edge on bit 0. Bit 0 remains 1 and IRQ = 1.
- Debounce (macro defined, DEB_CYCLES = 4): a DIN pulse of 3 cycles leaves IN_DATA unchanged and no status bit set. A sustained level appears in IN_DATA after edge k+5.
- Reset mid-operation: with EDGE_STATUS = 0x3 and DOUT = 0xAA, assert RESET_N low for one edge concurrent with a write. Status = 0, IRQ = 0, DOUT = OUT_RESET, write discarded.

Source files
------------

// File: rtl/gpio_mmio.sv
// -----------------------------------------------------------------------------
// gpio_mmio
//
// Memory-mapped GPIO peripheral: synchronised inputs, output register with
// atomic set/clear/toggle writes, per-bit rising/falling edge capture with a
// write-1-to-clear status register, a registered level interrupt, and a
// hex-digit register.
//
// Optional feature macro: GPIO_DEBOUNCE_EN
//   defined   -> each input bit has a stability counter; a new level is
//                accepted only after it has persisted for DEB_CYCLES cycles.
//   undefined -> the conditioned input is the synchroniser output directly.
//
// Parameters
//   N_IN       number of input pins (1..32)
//   N_OUT      number of output pins (1..32)
//   N_HEX      number of 4-bit hex digit fields (1..8)
//   OUT_RESET  reset value of the output register
//   DEB_CYCLES debounce stability window in cycles (>= 2), debounce build only
//
// Ports
//   CLK             system clock, rising edge
//   RESET_N         synchronous active-low reset
//   DIN             asynchronous input pins
//   address         byte address; register select is address[5:2]
//   MemGPIOWrite    single-cycle write strobe
//   MemGPIO         write data
//   read_data_GPIO  combinational read data
//   DOUT            output register
//   HEX             hex digit register
//   IRQ             registered OR of the edge status bits
//
// Register map (byte offset)
//   0x00 IN_DATA (RO)   0x04 OUT_DATA (RW)   0x08 OUT_SET (WO)
//   0x0C OUT_CLR (WO)   0x10 OUT_TGL (WO)    0x14 RISE_EN (RW)
//   0x18 FALL_EN (RW)   0x1C EDGE_STATUS (RW1C)  0x20 HEX_DATA (RW)
//   All other offsets read 0 and ignore writes.
// -----------------------------------------------------------------------------
module gpio_mmio #(
  parameter int              N_IN       = 17,
  parameter int              N_OUT      = 27,
  parameter int              N_HEX      = 1,
  parameter logic [N_OUT-1:0] OUT_RESET = '0,
  parameter int              DEB_CYCLES = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [N_IN-1:0]      DIN,
  input  logic [10:0]          address,
  input  logic                 MemGPIOWrite,
  input  logic [31:0]          MemGPIO,
  output logic [31:0]          read_data_GPIO,
  output logic [N_OUT-1:0]     DOUT,
  output logic [4*N_HEX-1:0]   HEX,
  output logic                 IRQ
);

  localparam int HEX_W = 4 * N_HEX;

  localparam logic [3:0] SEL_IN_DATA     = 4'h0;
  localparam logic [3:0] SEL_OUT_DATA    = 4'h1;
  localparam logic [3:0] SEL_OUT_SET     = 4'h2;
  localparam logic [3:0] SEL_OUT_CLR     = 4'h3;
  localparam logic [3:0] SEL_OUT_TGL     = 4'h4;
  localparam logic [3:0] SEL_RISE_EN     = 4'h5;
  localparam logic [3:0] SEL_FALL_EN     = 4'h6;
  localparam logic [3:0] SEL_EDGE_STATUS = 4'h7;
  localparam logic [3:0] SEL_HEX_DATA    = 4'h8;

  logic [3:0]       sel;

  logic [N_OUT-1:0] out_reg,       out_next;
  logic [HEX_W-1:0] hex_reg,       hex_next;
  logic [N_IN-1:0]  rise_en_reg,   rise_en_next;
  logic [N_IN-1:0]  fall_en_reg,   fall_en_next;
  logic [N_IN-1:0]  status_reg,    status_next;
  logic             irq_reg;

  logic [N_IN-1:0]  sync1_reg;
  logic [N_IN-1:0]  sync2_reg;
  logic [N_IN-1:0]  prev_reg;
  logic [N_IN-1:0]  stable;

  logic [N_IN-1:0]  w1c_mask;
  logic [N_IN-1:0]  rise;
  logic [N_IN-1:0]  fall;

  assign sel = address[5:2];

  // ---------------------------------------------------------------------------
  // Conditioned input: either the synchroniser output or a debounced copy.
  // ---------------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_debounce
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_bit_reg;

    // The counter only runs while sync2 disagrees with the accepted level;
    // any return to agreement restarts the window from zero.
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        cnt_reg        <= '0;
        stable_bit_reg <= 1'b0;
      end else if (sync2_reg[gi] != stable_bit_reg) begin
        if (cnt_reg == CNT_LAST) begin
          stable_bit_reg <= sync2_reg[gi];
          cnt_reg        <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end

    assign stable[gi] = stable_bit_reg;
  end

  logic unused_bits;
  assign unused_bits = ^{address[10:6], address[1:0], MemGPIO};
`else
  assign stable = sync2_reg;

  logic unused_bits;
  assign unused_bits = ^{address[10:6], address[1:0], MemGPIO, DEB_CYCLES[0]};
`endif

  // ---------------------------------------------------------------------------
  // Register write decode and edge capture
  // ---------------------------------------------------------------------------
  always_comb begin
    out_next     = out_reg;
    hex_next     = hex_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    w1c_mask     = '0;

    if (MemGPIOWrite) begin
      case (sel)
        SEL_OUT_DATA:    out_next     = MemGPIO[N_OUT-1:0];
        SEL_OUT_SET:     out_next     = out_reg | MemGPIO[N_OUT-1:0];
        SEL_OUT_CLR:     out_next     = out_reg & ~MemGPIO[N_OUT-1:0];
        SEL_OUT_TGL:     out_next     = out_reg ^ MemGPIO[N_OUT-1:0];
        SEL_RISE_EN:     rise_en_next = MemGPIO[N_IN-1:0];
        SEL_FALL_EN:     fall_en_next = MemGPIO[N_IN-1:0];
        SEL_EDGE_STATUS: w1c_mask     = MemGPIO[N_IN-1:0];
        SEL_HEX_DATA:    hex_next     = MemGPIO[HEX_W-1:0];
        default: ;
      endcase
    end

    rise = stable & ~prev_reg & rise_en_reg;
    fall = ~stable & prev_reg & fall_en_reg;

    // New edges are OR-ed in after the clear so a coincident set wins.
    status_next = (status_reg & ~w1c_mask) | rise | fall;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_reg     <= OUT_RESET;
      hex_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      status_reg  <= '0;
      irq_reg     <= 1'b0;
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      prev_reg    <= '0;
    end else begin
      out_reg     <= out_next;
      hex_reg     <= hex_next;
      rise_en_reg <= rise_en_next;
      fall_en_reg <= fall_en_next;
      status_reg  <= status_next;
      irq_reg     <= |status_next;
      sync1_reg   <= DIN;
      sync2_reg   <= sync1_reg;
      prev_reg    <= stable;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: write-only and unmapped offsets return zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    read_data_GPIO = '0;
    case (sel)
      SEL_IN_DATA:     read_data_GPIO[N_IN-1:0]  = stable;
      SEL_OUT_DATA:    read_data_GPIO[N_OUT-1:0] = out_reg;
      SEL_RISE_EN:     read_data_GPIO[N_IN-1:0]  = rise_en_reg;
      SEL_FALL_EN:     read_data_GPIO[N_IN-1:0]  = fall_en_reg;
      SEL_EDGE_STATUS: read_data_GPIO[N_IN-1:0]  = status_reg;
      SEL_HEX_DATA:    read_data_GPIO[HEX_W-1:0] = hex_reg;
      default: ;
    endcase
  end

  assign DOUT = out_reg;
  assign HEX  = hex_reg;
  assign IRQ  = irq_reg;

endmodule

// File: tb/tb_gpio_mmio.sv
// -----------------------------------------------------------------------------
// tb_gpio_mmio
//
// Self-checking bench for gpio_mmio. A behavioural model tracks the register
// file and derives the conditioned input from a history of sampled DIN values;
// a negedge process compares DOUT, HEX, IRQ and read data against it every
// cycle. Directed sequences with literal expectations pin the model, followed
// by a randomized phase.
// -----------------------------------------------------------------------------
module tb_gpio_mmio;

  localparam int               N_IN    = 17;
  localparam int               N_OUT   = 27;
  localparam int               N_HEX   = 1;
  localparam logic [N_OUT-1:0] OUT_RST = 27'h5;
  localparam int               TB_DEB  = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB_EN  = 1'b1;
  localparam int LAT_CAP = TB_DEB + 3;  // edges from DIN change to status set
`else
  localparam bit DEB_EN  = 1'b0;
  localparam int LAT_CAP = 3;
`endif
  localparam int HIST = TB_DEB + 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_IN-1:0]     din;
  logic [10:0]         address;
  logic                we;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic [N_OUT-1:0]    dout;
  logic [4*N_HEX-1:0]  hex;
  logic                irq;

  int checks = 0;
  int errors = 0;

  gpio_mmio #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_HEX(N_HEX),
    .OUT_RESET(OUT_RST), .DEB_CYCLES(TB_DEB)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .DIN(din), .address(address),
    .MemGPIOWrite(we), .MemGPIO(wdata), .read_data_GPIO(rdata),
    .DOUT(dout), .HEX(hex), .IRQ(irq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit                  model_valid = 1'b0;
  logic [N_OUT-1:0]    m_out;
  logic [4*N_HEX-1:0]  m_hex;
  logic [N_IN-1:0]     m_rise_en, m_fall_en, m_status, m_stable, m_prev;
  logic                m_irq;
  logic [N_IN-1:0]     din_hist[$];   // [0] = DIN sampled at the latest edge

  always @(posedge clk) begin
    logic [N_IN-1:0]  rise, fall, clr;
    logic [N_OUT-1:0] wd;
    bit               all_diff;
    if (rst_n === 1'b0) begin
      m_out = OUT_RST; m_hex = '0; m_rise_en = '0; m_fall_en = '0;
      m_status = '0; m_irq = 1'b0; m_stable = '0; m_prev = '0;
      din_hist.delete();
      for (int i = 0; i < HIST; i++) din_hist.push_back('0);
      model_valid = 1'b1;
    end else if (model_valid) begin
      wd   = wdata[N_OUT-1:0];
      clr  = (we && address[5:2] == 4'd7) ? wdata[N_IN-1:0] : '0;
      rise = m_stable & ~m_prev & m_rise_en;
      fall = ~m_stable & m_prev & m_fall_en;
      m_status = (m_status & ~clr) | rise | fall;
      m_irq    = (m_status != '0);
      m_prev   = m_stable;
      if (we) begin
        case (address[5:2])
          4'd1: m_out = wd;
          4'd2: m_out = m_out | wd;
          4'd3: m_out = m_out & ~wd;
          4'd4: m_out = m_out ^ wd;
          4'd5: m_rise_en = wdata[N_IN-1:0];
          4'd6: m_fall_en = wdata[N_IN-1:0];
          4'd8: m_hex = wdata[4*N_HEX-1:0];
          default: ;
        endcase
      end
      din_hist.push_front(din);
      void'(din_hist.pop_back());
      if (DEB_EN) begin
        // A level is accepted once the last TB_DEB synchronised samples
        // (DIN two edges late) all disagree with the current level.
        for (int b = 0; b < N_IN; b++) begin
          all_diff = 1'b1;
          for (int j = 0; j < TB_DEB; j++)
            if (din_hist[2 + j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) m_stable[b] = ~m_stable[b];
        end
      end else begin
        m_stable = din_hist[1];
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [10:0] a);
    logic [31:0] r;
    r = '0;
    case (a[5:2])
      4'd0: r[N_IN-1:0]    = m_stable;
      4'd1: r[N_OUT-1:0]   = m_out;
      4'd5: r[N_IN-1:0]    = m_rise_en;
      4'd6: r[N_IN-1:0]    = m_fall_en;
      4'd7: r[N_IN-1:0]    = m_status;
      4'd8: r[4*N_HEX-1:0] = m_hex;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t addr=0x%0h)", name, act, exp, $time, address);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("dout",      32'(dout), 32'(m_out));
      check("hex",       32'(hex),  32'(m_hex));
      check("irq",       32'(irq),  32'(m_irq));
      check("read_data", rdata,     exp_rd(address));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    address = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rdata, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences, then randomized traffic
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; din = '0; address = '0; we = 1'b0; wdata = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    check("rst_dout", 32'(dout), 32'h5);
    check("rst_hex",  32'(hex),  32'h0);
    check("rst_irq",  32'(irq),  32'h0);
    rd_check("rst_status", 11'h01C, 32'h0);
    rd_check("rst_in_data", 11'h000, 32'h0);

    // Output atomics
    wr(11'h004, 32'hF0); check("out_write", 32'(dout), 32'hF0);
    wr(11'h008, 32'h0F); check("out_set",   32'(dout), 32'hFF);
    wr(11'h00C, 32'h30); check("out_clr",   32'(dout), 32'hCF);
    wr(11'h010, 32'h81); check("out_tgl",   32'(dout), 32'h4E);
    rd_check("out_set_reads_zero", 11'h008, 32'h0);
    rd_check("out_data_read", 11'h004, 32'h4E);

    // Hex field: excess bits ignored
    wr(11'h020, 32'hFFFF_FFFF);
    check("hex_write", 32'(hex), 32'hF);
    rd_check("hex_read", 11'h020, 32'hF);
    rd_check("unmapped_read", 11'h024, 32'h0);

    // Edge capture
    din = 17'h2;
    repeat (LAT_CAP + 1) step();
    wr(11'h014, 32'h1);
    wr(11'h018, 32'h2);
    rd_check("status_idle", 11'h01C, 32'h0);
    din = 17'h3;                       // rising edge on bit 0
    repeat (LAT_CAP - 1) step();
    rd_check("rise_not_yet", 11'h01C, 32'h0);
    check("irq_not_yet", 32'(irq), 32'h0);
    step();
    rd_check("rise_captured", 11'h01C, 32'h1);
    check("irq_rise", 32'(irq), 32'h1);
    din = 17'h1;                       // falling edge on bit 1
    repeat (LAT_CAP) step();
    rd_check("fall_captured", 11'h01C, 32'h3);
    wr(11'h01C, 32'h1);
    rd_check("w1c_bit0", 11'h01C, 32'h2);
    check("irq_after_w1c0", 32'(irq), 32'h1);
    wr(11'h01C, 32'h2);
    rd_check("w1c_bit1", 11'h01C, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // Set/clear collision on bit 0
    din = 17'h0;                       // falling bit 0 is not enabled
    repeat (LAT_CAP + 1) step();
    rd_check("fall_disabled", 11'h01C, 32'h0);
    din = 17'h1;
    repeat (LAT_CAP) step();
    rd_check("rise_again", 11'h01C, 32'h1);
    din = 17'h0;
    repeat (LAT_CAP + 1) step();
    din = 17'h1;
    repeat (LAT_CAP - 1) step();
    wr(11'h01C, 32'h1);                // lands on the capture edge
    rd_check("collision_set_wins", 11'h01C, 32'h1);
    check("collision_irq", 32'(irq), 32'h1);
    wr(11'h01C, 32'h1);
    rd_check("collision_cleared", 11'h01C, 32'h0);

    // Reset in the middle of activity, coincident with a write
    din = 17'h2;
    repeat (LAT_CAP + 1) step();
    rd_check("pre_reset_quiet", 11'h01C, 32'h0);
    din = 17'h1;                       // bit 0 rises, bit 1 falls
    repeat (LAT_CAP + 1) step();
    rd_check("pre_reset_status", 11'h01C, 32'h3);
    wr(11'h004, 32'hAA);
    check("pre_reset_dout", 32'(dout), 32'hAA);
    rst_n = 1'b0; address = 11'h004; wdata = 32'h55; we = 1'b1;
    step();
    rst_n = 1'b1; we = 1'b0;
    check("mid_reset_dout", 32'(dout), 32'h5);
    check("mid_reset_irq",  32'(irq),  32'h0);
    check("mid_reset_hex",  32'(hex),  32'h0);
    rd_check("mid_reset_status", 11'h01C, 32'h0);
    rd_check("mid_reset_rise_en", 11'h014, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short pulse rejected, sustained level accepted
    wr(11'h014, 32'h4);
    din = 17'h5;
    repeat (3) step();
    din = 17'h1;
    repeat (TB_DEB + 4) step();
    rd_check("glitch_in_data", 11'h000, 32'h1);
    rd_check("glitch_status", 11'h01C, 32'h0);
    din = 17'h5;
    repeat (TB_DEB + 1) step();
    rd_check("deb_not_yet", 11'h000, 32'h1);
    step();
    rd_check("deb_accepted", 11'h000, 32'h5);
    step();
    rd_check("deb_status", 11'h01C, 32'h4);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int b;
      if (DEB_EN) begin
        if ($urandom_range(0, 5) == 0) begin
          b = int'($urandom_range(0, N_IN - 1));
          din[b] = ~din[b];
        end
      end else if ($urandom_range(0, 2) == 0) begin
        din = N_IN'($urandom);
      end
      address = 11'($urandom);
      if ($urandom_range(0, 7) != 0) address[5:2] = 4'($urandom_range(0, 8));
      wdata = $urandom;
      we    = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; we = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
